// File: rtl/pipeline_hazard_controller_pkg.sv
// Shared types and widths for the pipeline hazard controller.
// Optional feature macro: HAZARD_PERF_EN (stall-cycle performance counter).
package hazard_pkg;

  localparam int REG_ADDR_W_DEF = 3;
  localparam int FLUSH_CNT_W    = 3;
  localparam int PERF_CNT_W     = 16;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_FLUSH    = 2'd1,
    ST_MEM_WAIT = 2'd2,
    ST_HALTED   = 2'd3
  } hz_state_e;

endpackage

// File: rtl/pipeline_hazard_controller_if.sv
// Hazard-controller bus: pipeline status in, stage enables/flushes out.
// The master side is the pipeline, the slave side is the controller.
interface pipeline_hazard_controller_if import hazard_pkg::*; #(
  parameter int REG_ADDR_W = REG_ADDR_W_DEF
);

  logic [REG_ADDR_W-1:0] id_rs_addr_i;
  logic [REG_ADDR_W-1:0] id_rt_addr_i;
  logic                  id_uses_rs_i;
  logic                  id_uses_rt_i;
  logic [REG_ADDR_W-1:0] ex_write_addr_i;
  logic                  ex_memread_i;
  logic                  ex_branch_taken_i;
  logic                  mem_req_i;
  logic                  mem_ack_i;
  logic                  halt_i;
  logic                  resume_i;

  logic                  pc_en_o;
  logic                  ifid_en_o;
  logic                  ifid_flush_o;
  logic                  idex_en_o;
  logic                  idex_bubble_o;
  logic                  exmem_en_o;
  logic                  memwb_bubble_o;
  logic                  halted_o;
  logic [2:0]            state_o;
  logic [PERF_CNT_W-1:0] stall_cycles_o;

  modport master (
    output id_rs_addr_i, id_rt_addr_i, id_uses_rs_i, id_uses_rt_i,
           ex_write_addr_i, ex_memread_i, ex_branch_taken_i,
           mem_req_i, mem_ack_i, halt_i, resume_i,
    input  pc_en_o, ifid_en_o, ifid_flush_o, idex_en_o, idex_bubble_o,
           exmem_en_o, memwb_bubble_o, halted_o, state_o, stall_cycles_o
  );

  modport slave (
    input  id_rs_addr_i, id_rt_addr_i, id_uses_rs_i, id_uses_rt_i,
           ex_write_addr_i, ex_memread_i, ex_branch_taken_i,
           mem_req_i, mem_ack_i, halt_i, resume_i,
    output pc_en_o, ifid_en_o, ifid_flush_o, idex_en_o, idex_bubble_o,
           exmem_en_o, memwb_bubble_o, halted_o, state_o, stall_cycles_o
  );

endinterface

// File: rtl/pipeline_hazard_controller_load_use_detect.sv
// Load-use hazard detector: a load in EX whose destination is read by the
// instruction in ID cannot be forwarded in time. Purely combinational.
module load_use_detect import hazard_pkg::*; #(
  parameter int REG_ADDR_W = REG_ADDR_W_DEF
) (
  input  logic [REG_ADDR_W-1:0] id_rs_addr,
  input  logic [REG_ADDR_W-1:0] id_rt_addr,
  input  logic                  id_uses_rs,
  input  logic                  id_uses_rt,
  input  logic [REG_ADDR_W-1:0] ex_write_addr,
  input  logic                  ex_memread,
  output logic                  hazard
);

  // Register 0 is compared like any other address.
  always_comb begin
    hazard = ex_memread &
             ((id_uses_rs & (id_rs_addr == ex_write_addr)) |
              (id_uses_rt & (id_rt_addr == ex_write_addr)));
  end

endmodule

// File: rtl/pipeline_hazard_controller.sv
// Central stall/flush sequencer for the IF/ID/EX/EM/WB pipeline.
// Outputs are combinational (same-cycle response); state is registered.
// Optional feature macro: HAZARD_PERF_EN adds a saturating stall counter.
module pipeline_hazard_controller import hazard_pkg::*; #(
  parameter int REG_ADDR_W   = REG_ADDR_W_DEF,
  parameter int FLUSH_CYCLES = 1
) (
  input  logic                       clk_i,
  input  logic                       rst_n_i,
  pipeline_hazard_controller_if.slave bus
);

  localparam logic [FLUSH_CNT_W-1:0] FLUSH_LOAD  = FLUSH_CNT_W'(FLUSH_CYCLES - 1);
  localparam bit                     MULTI_FLUSH = (FLUSH_CYCLES > 1);

  hz_state_e              state, state_nxt;
  logic [FLUSH_CNT_W-1:0] flush_cnt, flush_cnt_nxt;
  logic                   ret_halted, ret_halted_nxt;
  logic                   load_use;
  logic                   mem_freeze;
  logic                   freeze_out;
  logic                   pc_en, ifid_en, ifid_flush, idex_en, idex_bubble;
  logic                   exmem_en, memwb_bubble;

  load_use_detect #(.REG_ADDR_W(REG_ADDR_W)) u_load_use (
    .id_rs_addr    (bus.id_rs_addr_i),
    .id_rt_addr    (bus.id_rt_addr_i),
    .id_uses_rs    (bus.id_uses_rs_i),
    .id_uses_rt    (bus.id_uses_rt_i),
    .ex_write_addr (bus.ex_write_addr_i),
    .ex_memread    (bus.ex_memread_i),
    .hazard        (load_use)
  );

  // An ack in the same cycle as the request completes it without freezing.
  assign mem_freeze = bus.mem_req_i & ~bus.mem_ack_i;

  // Priority mux and next-state logic; only the winning event acts.
  always_comb begin
    pc_en          = 1'b1;
    ifid_en        = 1'b1;
    ifid_flush     = 1'b0;
    idex_en        = 1'b1;
    idex_bubble    = 1'b0;
    exmem_en       = 1'b1;
    memwb_bubble   = 1'b0;
    freeze_out     = 1'b0;
    state_nxt      = state;
    flush_cnt_nxt  = flush_cnt;
    ret_halted_nxt = ret_halted;
    case (state)
      ST_RUN: begin
        if (mem_freeze) begin
          freeze_out     = 1'b1;
          state_nxt      = ST_MEM_WAIT;
          ret_halted_nxt = 1'b0;
        end else if (bus.ex_branch_taken_i) begin
          // Coincident load-use or HALT in ID is wrong-path and dropped.
          ifid_flush  = 1'b1;
          idex_bubble = 1'b1;
          if (MULTI_FLUSH) begin
            state_nxt     = ST_FLUSH;
            flush_cnt_nxt = FLUSH_LOAD;
          end
        end else if (load_use) begin
          pc_en       = 1'b0;
          ifid_en     = 1'b0;
          idex_bubble = 1'b1;
        end else if (bus.halt_i) begin
          state_nxt = ST_HALTED;
        end
      end
      ST_FLUSH: begin
        if (mem_freeze) begin
          freeze_out     = 1'b1;
          state_nxt      = ST_MEM_WAIT;
          ret_halted_nxt = 1'b0;
          flush_cnt_nxt  = '0;
        end else begin
          ifid_flush = 1'b1;
          if (flush_cnt <= FLUSH_CNT_W'(1)) begin
            state_nxt     = ST_RUN;
            flush_cnt_nxt = '0;
          end else begin
            flush_cnt_nxt = flush_cnt - FLUSH_CNT_W'(1);
          end
        end
      end
      ST_MEM_WAIT: begin
        if (!bus.mem_ack_i) begin
          freeze_out = 1'b1;
        end else begin
          state_nxt      = ret_halted ? ST_HALTED : ST_RUN;
          ret_halted_nxt = 1'b0;
        end
      end
      ST_HALTED: begin
        if (mem_freeze) begin
          freeze_out     = 1'b1;
          state_nxt      = ST_MEM_WAIT;
          ret_halted_nxt = 1'b1;
        end else begin
          // Front end held; EX/EM/WB keep draining.
          pc_en       = 1'b0;
          ifid_en     = 1'b0;
          idex_bubble = 1'b1;
          if (bus.resume_i) state_nxt = ST_RUN;
        end
      end
      default: state_nxt = ST_RUN;
    endcase
    if (freeze_out) begin
      pc_en        = 1'b0;
      ifid_en      = 1'b0;
      idex_en      = 1'b0;
      exmem_en     = 1'b0;
      memwb_bubble = 1'b1;
    end
  end

  // State, flush counter and return-to-HALTED flag.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state      <= ST_RUN;
      flush_cnt  <= '0;
      ret_halted <= 1'b0;
    end else begin
      state      <= state_nxt;
      flush_cnt  <= flush_cnt_nxt;
      ret_halted <= ret_halted_nxt;
    end
  end

  assign bus.pc_en_o        = pc_en;
  assign bus.ifid_en_o      = ifid_en;
  assign bus.ifid_flush_o   = ifid_flush;
  assign bus.idex_en_o      = idex_en;
  assign bus.idex_bubble_o  = idex_bubble;
  assign bus.exmem_en_o     = exmem_en;
  assign bus.memwb_bubble_o = memwb_bubble;
  assign bus.halted_o       = (state == ST_HALTED);
  assign bus.state_o        = {1'b0, state};

`ifdef HAZARD_PERF_EN
  logic [PERF_CNT_W-1:0] stall_cnt;

  function automatic logic [PERF_CNT_W-1:0] sat_inc(input logic [PERF_CNT_W-1:0] v);
    return (&v) ? v : v + PERF_CNT_W'(1);
  endfunction

  // Count every cycle the PC is held, saturating at all-ones.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i)    stall_cnt <= '0;
    else if (!pc_en) stall_cnt <= sat_inc(stall_cnt);
  end

  assign bus.stall_cycles_o = stall_cnt;
`else
  assign bus.stall_cycles_o = '0;
`endif

endmodule
